// File: rtl/seg7_pkg.sv
// seg7_pkg: constants, digit positions and the BCD -> 7-segment helper shared
// by the stopwatch display front end. Segment vectors are {g,f,e,d,c,b,a},
// logical polarity (1 = segment lit).
package seg7_pkg;

    localparam int N_DIG = 6;
    localparam int IDX_W = $clog2(N_DIG);

    typedef logic [IDX_W-1:0] dig_idx_t;
    typedef logic [6:0]       seg_t;

    // Scan order, leftmost digit first; hh.mm.ss separators sit after 1 and 3
    typedef enum logic [IDX_W-1:0] {
        DIG_HR_H  = IDX_W'(0),
        DIG_HR_L  = IDX_W'(1),
        DIG_MIN_H = IDX_W'(2),
        DIG_MIN_L = IDX_W'(3),
        DIG_SEC_H = IDX_W'(4),
        DIG_SEC_L = IDX_W'(5)
    } dig_pos_e;

    localparam dig_idx_t IDX_LAST = IDX_W'(N_DIG - 1);

    localparam seg_t SEG_0    = 7'b0111111;
    localparam seg_t SEG_1    = 7'b0000110;
    localparam seg_t SEG_2    = 7'b1011011;
    localparam seg_t SEG_3    = 7'b1001111;
    localparam seg_t SEG_4    = 7'b1100110;
    localparam seg_t SEG_5    = 7'b1101101;
    localparam seg_t SEG_6    = 7'b1111101;
    localparam seg_t SEG_7    = 7'b0000111;
    localparam seg_t SEG_8    = 7'b1111111;
    localparam seg_t SEG_9    = 7'b1101111;
    localparam seg_t SEG_DASH = 7'b1000000;
    localparam seg_t SEG_OFF  = 7'b0000000;

    // Non-BCD codes (10..15) show a dash so a corrupted counter is visible
    function automatic seg_t bcd_to_seg(input logic [3:0] bcd);
        seg_t s;
        case (bcd)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_DASH;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg7_scan_display_if.sv
// seg7_scan_display_if: digit bus from the stopwatch core plus the scanned
// display pins. master = stopwatch/board side, slave = the scan display.
interface seg7_scan_display_if;
    import seg7_pkg::*;

    logic             en;
    logic [3:0]       hr_h;
    logic [3:0]       hr_l;
    logic [3:0]       min_h;
    logic [3:0]       min_l;
    logic [3:0]       sec_h;
    logic [3:0]       sec_l;
    logic [6:0]       seg;
    logic             dp;
    logic [N_DIG-1:0] dig_sel;
    logic             frame_start;

    modport master (
        output en, hr_h, hr_l, min_h, min_l, sec_h, sec_l,
        input  seg, dp, dig_sel, frame_start
    );

    modport slave (
        input  en, hr_h, hr_l, min_h, min_l, sec_h, sec_l,
        output seg, dp, dig_sel, frame_start
    );

endinterface

// File: rtl/seg7_decode.sv
// seg7_decode: purely combinational BCD -> segment pattern (logical polarity).
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] bcd,
    output seg_t       seg
);

    assign seg = bcd_to_seg(bcd);

endmodule

// File: rtl/seg7_scan_display.sv
// seg7_scan_display: time-multiplexed 6-digit 7-segment driver for the
// stopwatch. Each digit slot is one blank (anti-ghost) cycle followed by
// SCAN_DIV-1 drive cycles. The six digits are snapshotted at the start of
// every frame so a counter update mid-scan never tears the display.
// SCAN_DIV must be at least 2.
// Optional build macro: BLANK_LEAD_ZERO_EN -- blank the hour-tens digit when
// it is zero (the digit still scans, only its segments stay dark).
module seg7_scan_display
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter bit POL_INV  = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    seg7_scan_display_if.slave   disp
);

    localparam int              PH_W     = $clog2(SCAN_DIV);
    localparam logic [PH_W-1:0] PH_LAST  = PH_W'(SCAN_DIV - 1);
    localparam logic [N_DIG-1:0] SEL_LEFT = {1'b1, {(N_DIG-1){1'b0}}};

    logic [PH_W-1:0]        phase;
    dig_idx_t               idx;
    logic [N_DIG-1:0][3:0]  shadow;
    logic [3:0]             cur_digit;
    seg_t                   dec_seg;
    logic                   snap;
    logic                   lead_blank;

    seg_t                   seg_n;
    logic                   dp_n;
    logic [N_DIG-1:0]       sel_n;
    logic                   fs_n;

    seg_t                   seg_q;
    logic                   dp_q;
    logic [N_DIG-1:0]       sel_q;
    logic                   fs_q;

    // Frame boundary: first (blank) cycle of slot 0 while the display is on
    assign snap = disp.en && (idx == DIG_HR_H) && (phase == '0);

    // Prescaler and digit index; disabling the display parks both at slot 0
    always_ff @(posedge clk) begin
        if (rst || !disp.en) begin
            phase <= '0;
            idx   <= '0;
        end else if (phase == PH_LAST) begin
            phase <= '0;
            idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            phase <= phase + 1'b1;
        end
    end

    // Capture all six digits once per frame so the whole frame is consistent
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow <= '0;
        end else if (snap) begin
            shadow <= {disp.sec_l, disp.sec_h, disp.min_l,
                       disp.min_h, disp.hr_l,  disp.hr_h};
        end
    end

    // Pick the snapshotted digit belonging to the slot being scanned
    always_comb begin
        cur_digit = 4'd0;
        case (idx)
            DIG_HR_H:  cur_digit = shadow[0];
            DIG_HR_L:  cur_digit = shadow[1];
            DIG_MIN_H: cur_digit = shadow[2];
            DIG_MIN_L: cur_digit = shadow[3];
            DIG_SEC_H: cur_digit = shadow[4];
            DIG_SEC_L: cur_digit = shadow[5];
            default:   cur_digit = 4'd0;
        endcase
    end

    seg7_decode u_decode (
        .bcd (cur_digit),
        .seg (dec_seg)
    );

`ifdef BLANK_LEAD_ZERO_EN
    assign lead_blank = (idx == DIG_HR_H) && (cur_digit == 4'd0);
`else
    assign lead_blank = 1'b0;
`endif

    // Logical next-state of the pins: blank on phase 0, drive the slot otherwise
    always_comb begin
        seg_n = SEG_OFF;
        dp_n  = 1'b0;
        sel_n = '0;
        fs_n  = snap;
        if (disp.en && (phase != '0)) begin
            sel_n = SEL_LEFT >> idx;
            seg_n = lead_blank ? SEG_OFF : dec_seg;
            dp_n  = (idx == DIG_HR_L) || (idx == DIG_MIN_L);
        end
    end

    // Output registers; polarity inversion happens only here at the pins
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q <= {7{POL_INV}};
            dp_q  <= POL_INV;
            sel_q <= {N_DIG{POL_INV}};
            fs_q  <= 1'b0;
        end else begin
            seg_q <= seg_n ^ {7{POL_INV}};
            dp_q  <= dp_n ^ POL_INV;
            sel_q <= sel_n ^ {N_DIG{POL_INV}};
            fs_q  <= fs_n;
        end
    end

    assign disp.seg         = seg_q;
    assign disp.dp          = dp_q;
    assign disp.dig_sel     = sel_q;
    assign disp.frame_start = fs_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// tb_seg7_scan_display: directed + randomized checks of the scan display
// against a frame-time reference model (SCAN_DIV=4, POL_INV=0).
// Honours BLANK_LEAD_ZERO_EN the same way the design does.
module tb_seg7_scan_display;

    localparam int SD    = 4;
    localparam int FRAME = SD * 6;

    logic clk = 1'b0;
    logic rst;

    seg7_scan_display_if dif ();

    seg7_scan_display #(
        .SCAN_DIV (SD),
        .POL_INV  (1'b0)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .disp (dif)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: cycle position inside the frame plus captured digits
    int         t = 0;
    logic [3:0] m_shadow [6];
    logic [6:0] seg_tab [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40
    };

    logic [6:0] e_seg;
    logic       e_dp;
    logic [5:0] e_sel;
    logic       e_fs;

    task automatic checkOutput(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s at t=%0t: observed %b expected %b", tag, $time, obs, exp);
        end
    endtask

    // One clock: predict from current inputs, clock, then compare all pins
    task automatic applyStimulus();
        logic [3:0] cur [6];
        int slot;
        int ph;
        cur[0] = dif.hr_h;  cur[1] = dif.hr_l;
        cur[2] = dif.min_h; cur[3] = dif.min_l;
        cur[4] = dif.sec_h; cur[5] = dif.sec_l;
        e_seg = 7'd0; e_dp = 1'b0; e_sel = 6'd0; e_fs = 1'b0;
        if (rst || !dif.en) begin
            t = 0;
        end else begin
            slot = t / SD;
            ph   = t % SD;
            if (t == 0) begin
                for (int i = 0; i < 6; i++) m_shadow[i] = cur[i];
                e_fs = 1'b1;
            end
            if (ph != 0) begin
                e_sel = 6'b100000 >> slot;
                e_seg = seg_tab[m_shadow[slot]];
`ifdef BLANK_LEAD_ZERO_EN
                if (slot == 0 && m_shadow[0] == 4'd0) e_seg = 7'd0;
`endif
                e_dp  = (slot == 1) || (slot == 3);
            end
            t = (t + 1) % FRAME;
        end
        @(posedge clk);
        #1;
        checkOutput("seg",         dif.seg,                {1'b0, 6'd0} | e_seg);
        checkOutput("dp",          {6'd0, dif.dp},          {6'd0, e_dp});
        checkOutput("dig_sel",     {1'b0, dif.dig_sel},     {1'b0, e_sel});
        checkOutput("frame_start", {6'd0, dif.frame_start}, {6'd0, e_fs});
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus();
    endtask

    initial begin
        int guard;
        for (int i = 0; i < 6; i++) m_shadow[i] = 4'd0;

        // Reset held two cycles with the display enabled
        rst = 1'b1;
        dif.en = 1'b1;
        dif.hr_h = 4'd1; dif.hr_l = 4'd2; dif.min_h = 4'd3;
        dif.min_l = 4'd4; dif.sec_h = 4'd5; dif.sec_l = 4'd6;
        runCycles(2);
        rst = 1'b0;

        // Digits 1..6, one full frame plus a bit
        runCycles(FRAME + 3);

        // Mid-frame change of seconds units must not tear the frame
        runCycles(7);
        dif.sec_l = 4'd7;
        runCycles(2 * FRAME);

        // Non-BCD code on minutes units shows a dash with its separator
        dif.min_l = 4'hA;
        runCycles(2 * FRAME);
        dif.min_l = 4'd4;

        // Disable during slot 3 drive, then re-enable
        guard = 0;
        while (t != 3 * SD + 2 && guard < 2 * FRAME) begin
            applyStimulus();
            guard++;
        end
        n_cmp++;
        assert (t == 3 * SD + 2) else begin
            n_fail++;
            $error("[TB] FAIL align_slot3: observed %0d required %0d", t, 3 * SD + 2);
        end
        dif.en = 1'b0;
        runCycles(3);
        dif.en = 1'b1;
        runCycles(FRAME + 2);

        // Leading hour-tens zero
        dif.hr_h = 4'd0;
        runCycles(2 * FRAME);

        // Reset in the middle of a frame
        runCycles(9);
        rst = 1'b1;
        runCycles(1);
        rst = 1'b0;
        runCycles(FRAME);

        // Randomized digits, enable drops and occasional resets
        for (int k = 0; k < 60; k++) begin
            dif.hr_h  = 4'($urandom_range(0, 15));
            dif.hr_l  = 4'($urandom_range(0, 15));
            dif.min_h = 4'($urandom_range(0, 15));
            dif.min_l = 4'($urandom_range(0, 15));
            dif.sec_h = 4'($urandom_range(0, 15));
            dif.sec_l = 4'($urandom_range(0, 15));
            dif.en    = ($urandom_range(0, 9) != 0);
            rst       = ($urandom_range(0, 19) == 0);
            runCycles($urandom_range(1, 30));
        end
        rst = 1'b0;
        dif.en = 1'b1;
        runCycles(FRAME);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
